// File: rtl/piece_ctrl_pkg.sv
// Playfield constants, command/state encodings and mask helpers shared by the
// piece controller and the rotator.
package piece_ctrl_pkg;

   localparam int COLS        = 12;
   localparam int ROWS        = 12;
   localparam int CELLS       = COLS * ROWS;
   localparam int PIECE_CELLS = 4;

   typedef enum logic [1:0] {
      CMD_LEFT   = 2'd0,
      CMD_RIGHT  = 2'd1,
      CMD_ROTATE = 2'd2,
      CMD_DROP   = 2'd3
   } cmd_e;

   typedef enum logic [2:0] {
      ST_SPAWN,
      ST_IDLE,
      ST_DROP,
      ST_LOCK,
      ST_SCAN,
      ST_SHIFT,
      ST_OVER
   } state_e;

   function automatic logic [CELLS-1:0] col_mask(input int c);
      logic [CELLS-1:0] m;
      m = '0;
      for (int r = 0; r < ROWS; r++) m[r*COLS + c] = 1'b1;
      return m;
   endfunction

   localparam logic [CELLS-1:0] COL0_MASK  = col_mask(0);
   localparam logic [CELLS-1:0] COL11_MASK = col_mask(COLS - 1);

   function automatic logic [CELLS-1:0] row_mask(input logic [3:0] r);
      logic [CELLS-1:0] m;
      m = '0;
      m[COLS-1:0] = '1;
      return m << (int'(r) * COLS);
   endfunction

   // Rows 0..r inclusive: the part of the field that slides down when row r clears.
   function automatic logic [CELLS-1:0] rows_upto_mask(input logic [3:0] r);
      return {CELLS{1'b1}} >> (CELLS - (int'(r) + 1) * COLS);
   endfunction

endpackage

// File: rtl/row_clear_unit.sv
// Settled background plus the bottom-up row scanner: merges a locked piece,
// detects full rows and collapses the rows above each one.
module row_clear_unit
   import piece_ctrl_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             lock,
   input  logic             scan,
   input  logic             shift,
   input  logic [CELLS-1:0] lock_sqs,
   output logic [CELLS-1:0] bg,
   output logic             row_full,
   output logic             done,
   output logic             line_inc
);

   logic [CELLS-1:0] bg_q, bg_d;
   logic [3:0]       row_q, row_d;
   logic [CELLS-1:0] cur_row, upto;

   always_comb begin
      // NOTE: every output of this block gets a value before any branch, so no latch is inferred.
      bg_d     = bg_q;
      row_d    = row_q;
      cur_row  = row_mask(row_q);
      upto     = rows_upto_mask(row_q);
      row_full = (bg_q & cur_row) == cur_row;
      done     = scan && !row_full && (row_q == 4'd0);
      line_inc = shift;

      if (lock) begin
         bg_d  = bg_q | lock_sqs;
         row_d = 4'(ROWS - 1);
      end else if (shift) begin
         // Row r is overwritten by row r-1; rows below r keep their contents.
         bg_d = (bg_q & ~upto) | ((bg_q << COLS) & upto);
      end else if (scan && !row_full && (row_q != 4'd0)) begin
         row_d = row_q - 4'd1;
      end
   end

   // NOTE: the background is a plain register bank, so it is cleared by reset like any other state.
   always_ff @(posedge clock) begin
      if (reset) begin
         bg_q  <= '0;
         row_q <= '0;
      end else begin
         bg_q  <= bg_d;
         row_q <= row_d;
      end
   end

   assign bg = bg_q;

endmodule

// File: rtl/piece_ctrl.sv
// Active-piece controller: validates move/rotate/gravity candidates against the
// background, locks landed pieces, sequences row clearing and spawns.
module piece_ctrl
   import piece_ctrl_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             tick,
   input  logic             cmd_valid,
   input  logic [1:0]       cmd,
   output logic             cmd_ready,
   input  logic [CELLS-1:0] rot_sqs,
   input  logic [CELLS-1:0] spawn_sqs,
   input  logic [9:0]       spawn_addr,
   output logic [CELLS-1:0] cur_sqs,
   output logic [9:0]       cur_addr,
   output logic [CELLS-1:0] background,
   output logic             busy,
   output logic             game_over,
   output logic [7:0]       lines
);

   state_e           state_q, state_d;
   logic [CELLS-1:0] cur_q, cur_d;
   logic [9:0]       addr_q, addr_d;
   logic [7:0]       lines_q, lines_d;
   logic             over_q, over_d;
   logic             tick_pend_q, tick_pend_d;

   logic             lock, scan, shift, row_full, done, line_inc;
   logic [CELLS-1:0] bg, left_sqs, right_sqs, down_sqs;
   logic             left_ok, right_ok, rot_ok, down_ok, gravity;

   row_clear_unit u_rcu (
      .clock    (clock),
      .reset    (reset),
      .lock     (lock),
      .scan     (scan),
      .shift    (shift),
      .lock_sqs (cur_q),
      .bg       (bg),
      .row_full (row_full),
      .done     (done),
      .line_inc (line_inc)
   );

   always_comb begin
      left_sqs  = cur_q >> 1;
      right_sqs = cur_q << 1;
      down_sqs  = cur_q << COLS;
      left_ok   = ((cur_q & COL0_MASK) == '0) && ((left_sqs & bg) == '0);
      right_ok  = ((cur_q & COL11_MASK) == '0) && ((right_sqs & bg) == '0);
      rot_ok    = ($countones(rot_sqs) == PIECE_CELLS) && ((rot_sqs & bg) == '0);
      down_ok   = ((cur_q & row_mask(4'(ROWS - 1))) == '0) && ((down_sqs & bg) == '0);
   end

   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      addr_d      = addr_q;
      over_d      = over_q;
      lines_d     = line_inc ? lines_q + 8'd1 : lines_q;
      tick_pend_d = tick_pend_q | (tick && (state_q != ST_IDLE) && (state_q != ST_OVER));
      gravity     = tick | tick_pend_q;
      cmd_ready   = 1'b0;
      lock        = 1'b0;
      scan        = 1'b0;
      shift       = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (gravity) begin
               tick_pend_d = 1'b0;
               if (down_ok) begin
                  cur_d  = down_sqs;
                  addr_d = addr_q + 10'(COLS);
               end else begin
                  state_d = ST_LOCK;
               end
            end else begin
               cmd_ready = !reset;
               // Rejected commands are still consumed; they just change nothing.
               if (cmd_valid) begin
                  case (cmd_e'(cmd))
                     CMD_LEFT:   if (left_ok) begin cur_d = left_sqs; addr_d = addr_q - 10'd1; end
                     CMD_RIGHT:  if (right_ok) begin cur_d = right_sqs; addr_d = addr_q + 10'd1; end
                     CMD_ROTATE: if (rot_ok) cur_d = rot_sqs;
                     CMD_DROP:   state_d = ST_DROP;
                  endcase
               end
            end
         end
         ST_DROP: begin
            if (down_ok) begin
               cur_d  = down_sqs;
               addr_d = addr_q + 10'(COLS);
            end else begin
               state_d = ST_LOCK;
            end
         end
         ST_LOCK: begin
            lock    = 1'b1;
            cur_d   = '0;
            state_d = ST_SCAN;
         end
         ST_SCAN: begin
            scan = 1'b1;
            if (row_full) begin
               state_d = ST_SHIFT;
            end else if (done) begin
               state_d     = ST_SPAWN;
               tick_pend_d = 1'b0;
            end
         end
         ST_SHIFT: begin
            shift   = 1'b1;
            state_d = ST_SCAN;
         end
         ST_SPAWN: begin
            if ((spawn_sqs & bg) != '0) begin
               over_d  = 1'b1;
               state_d = ST_OVER;
            end else begin
               cur_d   = spawn_sqs;
               addr_d  = spawn_addr;
               state_d = ST_IDLE;
            end
         end
         ST_OVER: state_d = ST_OVER;
         default: state_d = ST_SPAWN;
      endcase
   end

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_SPAWN;
         cur_q       <= '0;
         addr_q      <= '0;
         lines_q     <= '0;
         over_q      <= 1'b0;
         tick_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         addr_q      <= addr_d;
         lines_q     <= lines_d;
         over_q      <= over_d;
         tick_pend_q <= tick_pend_d;
      end
   end

   assign cur_sqs    = cur_q;
   assign cur_addr   = addr_q;
   assign background = bg;
   assign busy       = state_q != ST_IDLE;
   assign game_over  = over_q;
   assign lines      = lines_q;

endmodule

// File: tb/tb_piece_ctrl.sv
// Directed bench for piece_ctrl: spawn, moves, gravity priority, rotate,
// hard drop, double line clear and game over.
module tb_piece_ctrl;
   import piece_ctrl_pkg::*;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         tick = 1'b0;
   logic         cmd_valid = 1'b0;
   logic [1:0]   cmd = 2'd0;
   logic         cmd_ready;
   logic [143:0] rot_sqs = '0;
   logic [143:0] spawn_sqs = '0;
   logic [9:0]   spawn_addr = '0;
   logic [143:0] cur_sqs, background;
   logic [9:0]   cur_addr;
   logic         busy, game_over;
   logic [7:0]   lines;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   piece_ctrl dut (
      .clock      (clock),
      .reset      (reset),
      .tick       (tick),
      .cmd_valid  (cmd_valid),
      .cmd        (cmd),
      .cmd_ready  (cmd_ready),
      .rot_sqs    (rot_sqs),
      .spawn_sqs  (spawn_sqs),
      .spawn_addr (spawn_addr),
      .cur_sqs    (cur_sqs),
      .cur_addr   (cur_addr),
      .background (background),
      .busy       (busy),
      .game_over  (game_over),
      .lines      (lines)
   );

   function automatic logic [143:0] bits4(input int a, input int b, input int c, input int d);
      logic [143:0] m;
      m = '0;
      m[a] = 1'b1; m[b] = 1'b1; m[c] = 1'b1; m[d] = 1'b1;
      return m;
   endfunction

   function automatic logic [143:0] o_at(input int a);
      return bits4(a, a + 1, a + 12, a + 13);
   endfunction

   task automatic cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic send(input logic [1:0] c);
      cmd_valid = 1'b1;
      cmd       = c;
      cycle();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_settle(input string tag);
      int k;
      k = 0;
      while (busy && !game_over && k < 200) begin
         cycle();
         k++;
      end
      n_checks++;
      if (k >= 200) begin n_fail++; $display("FAIL %s_timeout: busy=%b after %0d cycles, want 0", tag, busy, k); end
   endtask

   // Piece starts at the spawn pivot (col 4); walk it to `col`, then hard drop.
   task automatic drop_at(input int col, input string tag);
      for (int i = 4; i > col; i--) send(CMD_LEFT);
      for (int i = 4; i < col; i++) send(CMD_RIGHT);
      send(CMD_DROP);
      wait_settle(tag);
   endtask

   task automatic test_reset();
      spawn_sqs  = o_at(4);
      spawn_addr = 10'd4;
      reset      = 1'b1;
      cycle();
      cycle();
      n_checks++; if (cur_sqs !== '0) begin n_fail++; $display("FAIL rst_cur: got %h want 0", cur_sqs); end
      n_checks++; if (cur_addr !== 10'd0) begin n_fail++; $display("FAIL rst_addr: got %0d want 0", cur_addr); end
      n_checks++; if (background !== '0) begin n_fail++; $display("FAIL rst_bg: got %h want 0", background); end
      n_checks++; if (lines !== 8'd0 || game_over !== 1'b0) begin n_fail++; $display("FAIL rst_lines_over: got %0d/%b want 0/0", lines, game_over); end
      n_checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL rst_ready_busy: got %b/%b want 0/1", cmd_ready, busy); end
      reset = 1'b0;
      cycle();
      n_checks++; if (cur_sqs !== o_at(4)) begin n_fail++; $display("FAIL spawn_cur: got %h want %h", cur_sqs, o_at(4)); end
      n_checks++; if (cur_addr !== 10'd4) begin n_fail++; $display("FAIL spawn_addr: got %0d want 4", cur_addr); end
      n_checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL spawn_ready_busy: got %b/%b want 1/0", cmd_ready, busy); end
   endtask

   task automatic test_left();
      for (int i = 0; i < 5; i++) begin
         cmd_valid = 1'b1;
         cmd       = CMD_LEFT;
         #1;
         n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL left_ready[%0d]: got %b want 1", i, cmd_ready); end
         cycle();
         cmd_valid = 1'b0;
         if (i >= 3) begin
            n_checks++; if (cur_addr !== 10'd0 || cur_sqs !== o_at(0)) begin n_fail++; $display("FAIL left_pos[%0d]: got addr %0d cur %h want 0 %h", i, cur_addr, cur_sqs, o_at(0)); end
         end
      end
   endtask

   task automatic test_tick_priority();
      for (int i = 0; i < 4; i++) send(CMD_RIGHT);
      n_checks++; if (cur_addr !== 10'd4) begin n_fail++; $display("FAIL right_back: got %0d want 4", cur_addr); end
      cmd_valid = 1'b1;
      cmd       = CMD_RIGHT;
      tick      = 1'b1;
      #1;
      n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL tick_ready: got %b want 0", cmd_ready); end
      cycle();
      tick = 1'b0;
      n_checks++; if (cur_addr !== 10'd16 || cur_sqs !== o_at(16)) begin n_fail++; $display("FAIL tick_down: got addr %0d cur %h want 16 %h", cur_addr, cur_sqs, o_at(16)); end
      #1;
      n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL after_tick_ready: got %b want 1", cmd_ready); end
      cycle();
      cmd_valid = 1'b0;
      n_checks++; if (cur_addr !== 10'd17 || cur_sqs !== o_at(17)) begin n_fail++; $display("FAIL late_right: got addr %0d cur %h want 17 %h", cur_addr, cur_sqs, o_at(17)); end
   endtask

   task automatic test_rotate();
      rot_sqs = bits4(17, 18, 29, 29);
      send(CMD_ROTATE);
      n_checks++; if (cur_sqs !== o_at(17)) begin n_fail++; $display("FAIL rot_3cells: got %h want %h", cur_sqs, o_at(17)); end
      rot_sqs = bits4(16, 17, 18, 19);
      send(CMD_ROTATE);
      n_checks++; if (cur_sqs !== bits4(16, 17, 18, 19) || cur_addr !== 10'd17) begin n_fail++; $display("FAIL rot_ok: got %h addr %0d want %h 17", cur_sqs, cur_addr, bits4(16, 17, 18, 19)); end
      rot_sqs = o_at(17);
      send(CMD_ROTATE);
      send(CMD_LEFT);
      n_checks++; if (cur_sqs !== o_at(16) || cur_addr !== 10'd16) begin n_fail++; $display("FAIL rot_back: got %h addr %0d want %h 16", cur_sqs, cur_addr, o_at(16)); end
   endtask

   task automatic test_drop();
      send(CMD_DROP);
      n_checks++; if (busy !== 1'b1 || cur_addr !== 10'd16) begin n_fail++; $display("FAIL drop_enter: got busy %b addr %0d want 1 16", busy, cur_addr); end
      for (int i = 0; i < 9; i++) begin
         tick = (i == 3);
         cycle();
      end
      tick = 1'b0;
      n_checks++; if (cur_addr !== 10'd124 || cur_sqs !== o_at(124)) begin n_fail++; $display("FAIL drop_land: got addr %0d cur %h want 124 %h", cur_addr, cur_sqs, o_at(124)); end
      wait_settle("drop");
      n_checks++; if (background !== o_at(124)) begin n_fail++; $display("FAIL drop_bg: got %h want %h", background, o_at(124)); end
      n_checks++; if (lines !== 8'd0 || cur_addr !== 10'd4 || cur_sqs !== o_at(4)) begin n_fail++; $display("FAIL drop_respawn: got lines %0d addr %0d want 0 4", lines, cur_addr); end
      n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL pend_cleared_ready: got %b want 1", cmd_ready); end
      cycle();
      n_checks++; if (cur_addr !== 10'd4) begin n_fail++; $display("FAIL pend_cleared_pos: got %0d want 4", cur_addr); end
   endtask

   task automatic test_clear();
      logic [143:0] exp_bg;
      drop_at(0, "c0a");
      drop_at(0, "c0b");
      drop_at(2, "c2");
      drop_at(6, "c6");
      drop_at(8, "c8");
      exp_bg = o_at(124) | o_at(120) | o_at(96) | o_at(122) | o_at(126) | o_at(128);
      n_checks++; if (background !== exp_bg || lines !== 8'd0) begin n_fail++; $display("FAIL preload_bg: got %h lines %0d want %h 0", background, lines, exp_bg); end
      drop_at(10, "c10");
      n_checks++; if (lines !== 8'd2) begin n_fail++; $display("FAIL clear_lines: got %0d want 2", lines); end
      n_checks++; if (background !== o_at(120)) begin n_fail++; $display("FAIL clear_bg: got %h want %h", background, o_at(120)); end
      n_checks++; if (cur_sqs !== o_at(4) || busy !== 1'b0) begin n_fail++; $display("FAIL clear_respawn: got %h busy %b want %h 0", cur_sqs, busy, o_at(4)); end
   endtask

   task automatic test_game_over();
      logic [143:0] exp_bg;
      for (int i = 0; i < 6; i++) drop_at(4, "stack");
      exp_bg = o_at(120) | o_at(124) | o_at(100) | o_at(76) | o_at(52) | o_at(28) | o_at(4);
      n_checks++; if (game_over !== 1'b1 || cur_sqs !== '0) begin n_fail++; $display("FAIL over_flag: got %b cur %h want 1 0", game_over, cur_sqs); end
      n_checks++; if (background !== exp_bg) begin n_fail++; $display("FAIL over_bg: got %h want %h", background, exp_bg); end
      tick      = 1'b1;
      cmd_valid = 1'b1;
      cmd       = CMD_LEFT;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL over_ready[%0d]: got %b busy %b want 0 1", i, cmd_ready, busy); end
         cycle();
      end
      n_checks++; if (background !== exp_bg || cur_sqs !== '0 || lines !== 8'd2 || game_over !== 1'b1) begin n_fail++; $display("FAIL over_hold: got lines %0d over %b want 2 1", lines, game_over); end
      reset = 1'b1;
      cycle();
      tick      = 1'b0;
      cmd_valid = 1'b0;
      n_checks++; if (game_over !== 1'b0 || background !== '0 || lines !== 8'd0 || cur_sqs !== '0) begin n_fail++; $display("FAIL over_reset: got over %b lines %0d want 0 0", game_over, lines); end
      reset = 1'b0;
      cycle();
      n_checks++; if (cur_sqs !== o_at(4) || busy !== 1'b0) begin n_fail++; $display("FAIL reset_respawn: got %h busy %b want %h 0", cur_sqs, busy, o_at(4)); end
   endtask

   initial begin
      test_reset();
      test_left();
      test_tick_priority();
      test_rotate();
      test_drop();
      test_clear();
      test_game_over();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within 200000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule
